// File: rtl/mcycle_pkg.sv
// rtl/mcycle_pkg.sv - shared states, enable indices and class flags for the multi-cycle sequencer
package mcycle_pkg;

    typedef enum logic [2:0] {
        ST_IF    = 3'd0,
        ST_ID    = 3'd1,
        ST_EX    = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5,
        ST_FAULT = 3'd6
    } state_e;

    localparam int EN_IF = 0;
    localparam int EN_ID = 1;
    localparam int EN_EX = 2;
    localparam int EN_MEM = 3;
    localparam int EN_WB = 4;
    localparam int EN_W = 5;

    typedef struct packed {
        logic load;
        logic store;
        logic rf_we;
    } class_t;

    function automatic logic misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts no-ack cycles of a memory handshake and flags the last allowed one
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    if (LIMIT > 0) begin : g_on
        localparam int W = $clog2(LIMIT + 1);
        localparam logic [W-1:0] LAST = W'(LIMIT - 1);

        logic [W-1:0] count;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (inc) begin
                count <= count + W'(1);
            end
        end

        // High during the wait cycle whose missing ack makes the LIMIT-th miss
        assign expired = inc && (count == LAST);
    end else begin : g_off
        logic unused_ok;
        assign unused_ok = ^{clk, rst, clear, inc};
        assign expired = 1'b0;
    end

endmodule

// File: rtl/mcycle_seq.sv
// rtl/mcycle_seq.sv - multi-cycle CPU sequencer: stage enables, PC, memory handshakes, debug halt, instret
module mcycle_seq
    import mcycle_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h1c000000),
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_rf_we,
    input  logic             jump_en,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             debug_halt,
    input  logic             debug_step,
    output logic [EN_W-1:0]  en,
    output logic             rf_we,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [CNT_W-1:0]  instret_q;
    class_t            cls_q;

    logic              in_wait;
    logic              ack_cur;
    logic              expired;
    logic              commit;
    logic              jump_bad;
    logic [XLEN-1:0]   pc_next;

    assign in_wait = (state_q == ST_IF) || (state_q == ST_MEM);
    assign ack_cur = (state_q == ST_IF) ? imem_ack : dmem_ack;

    mem_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_wait || ack_cur),
        .inc    (in_wait && !ack_cur),
        .expired(expired)
    );

    // Commit is the final cycle of an instruction, wherever its class ends it
    assign commit = ((state_q == ST_EX) && !cls_q.load && !cls_q.store && !cls_q.rf_we)
                 || ((state_q == ST_MEM) && dmem_ack && !cls_q.load)
                 ||  (state_q == ST_WB);
    assign jump_bad = jump_en && misaligned(jump_target[1:0]);
    assign pc_next  = jump_en ? jump_target : pc_q + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IF;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            cls_q     <= '0;
        end else if (commit) begin
            if (jump_bad) begin
                state_q <= ST_FAULT;
            end else begin
                pc_q      <= pc_next;
                instret_q <= instret_q + CNT_W'(1);
                state_q   <= debug_halt ? ST_HALT : ST_IF;
            end
        end else begin
            case (state_q)
                ST_IF: begin
                    if (imem_ack)     state_q <= ST_ID;
                    else if (expired) state_q <= ST_FAULT;
                end
                ST_ID: begin
                    cls_q   <= '{load: dec_load, store: dec_store, rf_we: dec_rf_we};
                    state_q <= ST_EX;
                end
                ST_EX:   state_q <= (cls_q.load || cls_q.store) ? ST_MEM : ST_WB;
                ST_MEM: begin
                    if (dmem_ack)     state_q <= ST_WB;
                    else if (expired) state_q <= ST_FAULT;
                end
                ST_HALT: begin
                    if (debug_step || !debug_halt) state_q <= ST_IF;
                end
                ST_FAULT: state_q <= ST_FAULT;
                default:  state_q <= ST_FAULT;
            endcase
        end
    end

    // Handshake and strobe outputs are held low for the whole reset assertion
    always_comb begin
        en          = '0;
        en[EN_IF]   = (state_q == ST_IF) && imem_ack;
        en[EN_ID]   = (state_q == ST_ID);
        en[EN_EX]   = (state_q == ST_EX);
        en[EN_MEM]  = (state_q == ST_MEM) && dmem_ack;
        en[EN_WB]   = (state_q == ST_WB);
        if (rst) en = '0;
    end

    assign imem_req  = !rst && (state_q == ST_IF);
    assign imem_addr = pc_q;
    assign dmem_req  = !rst && (state_q == ST_MEM);
    assign dmem_we   = dmem_req && cls_q.store;
    assign rf_we     = !rst && (state_q == ST_WB);
    assign halted    = !rst && (state_q == ST_HALT);
    assign fault     = !rst && (state_q == ST_FAULT);
    assign pc        = pc_q;
    assign state     = state_q;
    assign instret   = instret_q;

endmodule
